// File: rtl/pipe_stage.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that keeps in_ready off the out_ready path.
module pipe_stage #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 106,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state, state_nx;
    entry_t m_ent, s_ent;
    logic   m_valid, s_valid;
    logic   accept, drain;
    logic   load_m_in, load_m_skid, load_s;

    // Entry valid bits are decoded straight from the state register.
    assign m_valid = (state != ST_EMPTY);
    assign s_valid = (state == ST_SKID);

    generate
        if (SKID) begin : g_skid
            assign in_ready = !s_valid;
        end else begin : g_single
            assign in_ready = !m_valid || out_ready;
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign drain     = m_valid && out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ent.ctrl : '0;
    assign out_data  = m_ent.data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_comb begin
        state_nx    = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx  = ST_FULL;
                    load_m_in = 1'b1;
                end
            end
            ST_FULL: begin
                // Without a skid entry, accept in FULL always coincides with drain.
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_nx = ST_SKID;
                    load_s   = 1'b1;
                end else if (drain) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (drain) begin
                    state_nx    = ST_FULL;
                    load_m_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        // Flush drops everything, including an entry accepted this cycle.
        if (flush) begin
            state_nx    = ST_EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
            m_ent <= '0;
            s_ent <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                m_ent.ctrl <= '0;
                s_ent.ctrl <= '0;
            end else begin
                if (load_m_in) begin
                    m_ent.ctrl <= in_ctrl;
                    m_ent.data <= in_data;
                end else if (load_m_skid) begin
                    m_ent <= s_ent;
                end
                if (load_s) begin
                    s_ent.ctrl <= in_ctrl;
                    s_ent.data <= in_data;
                end
            end
        end
    end

endmodule
